// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM arbiter.
package bram_arb_pkg;

    typedef logic port_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } arb_state_t;

    localparam port_idx_t PORT_DMV  = 1'b0;
    localparam port_idx_t PORT_HOST = 1'b1;

    // One-hot request/grant vector for a port index.
    function automatic logic [1:0] port_onehot(input port_idx_t p);
        return (p == PORT_HOST) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bram_arb_rr.sv
// Two-way round-robin picker. With BRAM_ARB_LOCK_EN defined, a hold vector
// restricts the candidates to the port that currently owns the lock.
module bram_arb_rr
    import bram_arb_pkg::*;
(
    input  logic [1:0] elig_i,
    input  port_idx_t  ptr_i,
`ifdef BRAM_ARB_LOCK_EN
    input  logic [1:0] hold_i,
`endif
    output logic [1:0] win_o,
    output port_idx_t  ptr_nxt_o
);

    logic [1:0] cand;
    logic [1:0] win;

    // Pick the winner and advance the pointer away from it.
    always_comb begin
        cand      = elig_i;
`ifdef BRAM_ARB_LOCK_EN
        if (|hold_i) begin
            cand = elig_i & hold_i;
        end
`endif
        win       = cand;
        ptr_nxt_o = ptr_i;
        if (&cand) begin
            win = port_onehot(ptr_i);
        end
        if (win[PORT_DMV]) begin
            ptr_nxt_o = PORT_HOST;
        end else if (win[PORT_HOST]) begin
            ptr_nxt_o = PORT_DMV;
        end
        win_o = win;
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency BRAM between the datamover data
// port (port 0) and a host/debug loader (port 1) with a registered req/gnt
// handshake and round-robin arbitration.
// Optional: BRAM_ARB_LOCK_EN adds m0_lock/m1_lock to keep ownership.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned DWIDTH = 32
) (
`ifdef BRAM_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    input  logic              clk,
    input  logic              rstn,
    input  logic              m0_req,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic              m0_wen,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DWIDTH-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic              m1_wen,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [AWIDTH-1:0] daddr,
    output logic              denb,
    output logic              dwenb,
    output logic [DWIDTH-1:0] dout,
    input  logic [DWIDTH-1:0] din
);

    arb_state_t        state_q, state_d;
    port_idx_t         ptr_q, ptr_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              denb_q, denb_d;
    logic              dwenb_q, dwenb_d;
    logic [AWIDTH-1:0] daddr_q, daddr_d;
    logic [DWIDTH-1:0] dout_q, dout_d;

    logic [1:0]        elig;
    logic [1:0]        win;
    port_idx_t         ptr_nxt;

`ifdef BRAM_ARB_LOCK_EN
    logic              last_vld_q, last_vld_d;
    logic [1:0]        hold;

    // Last-granted port (opposite of the pointer) keeps ownership while it locks.
    always_comb begin
        hold           = '0;
        hold[PORT_DMV]  = last_vld_q && (ptr_q == PORT_HOST) && m0_lock && m0_req;
        hold[PORT_HOST] = last_vld_q && (ptr_q == PORT_DMV)  && m1_lock && m1_req;
        last_vld_d     = last_vld_q | (|win);
    end
`endif

    // A port granted this cycle cannot be re-granted on the same held request.
    always_comb begin
        elig            = '0;
        elig[PORT_DMV]  = m0_req && (state_q != ACC0);
        elig[PORT_HOST] = m1_req && (state_q != ACC1);
    end

    bram_arb_rr u_rr (
        .elig_i    (elig),
        .ptr_i     (ptr_q),
`ifdef BRAM_ARB_LOCK_EN
        .hold_i    (hold),
`endif
        .win_o     (win),
        .ptr_nxt_o (ptr_nxt)
    );

    // Next-state and registered BRAM/handshake outputs.
    always_comb begin
        state_d  = IDLE;
        ptr_d    = ptr_nxt;
        gnt_d    = '0;
        denb_d   = 1'b0;
        dwenb_d  = 1'b0;
        daddr_d  = daddr_q;
        dout_d   = dout_q;
        rvalid_d = '0;
        if (!dwenb_q) begin
            rvalid_d[PORT_DMV]  = (state_q == ACC0);
            rvalid_d[PORT_HOST] = (state_q == ACC1);
        end
        case (win)
            2'b01: begin
                state_d = ACC0;
                gnt_d   = 2'b01;
                denb_d  = 1'b1;
                dwenb_d = m0_wen;
                daddr_d = m0_addr;
                dout_d  = m0_wdata;
            end
            2'b10: begin
                state_d = ACC1;
                gnt_d   = 2'b10;
                denb_d  = 1'b1;
                dwenb_d = m1_wen;
                daddr_d = m1_addr;
                dout_d  = m1_wdata;
            end
            default: ;
        endcase
    end

    // State register; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ptr_q    <= PORT_DMV;
            gnt_q    <= '0;
            rvalid_q <= '0;
            denb_q   <= 1'b0;
            dwenb_q  <= 1'b0;
            daddr_q  <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            denb_q   <= denb_d;
            dwenb_q  <= dwenb_d;
            daddr_q  <= daddr_d;
            dout_q   <= dout_d;
        end
    end

`ifdef BRAM_ARB_LOCK_EN
    // Lock ownership only exists once some port has been granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_vld_q <= 1'b0;
        end else begin
            last_vld_q <= last_vld_d;
        end
    end
`endif

    assign m0_gnt    = gnt_q[PORT_DMV];
    assign m1_gnt    = gnt_q[PORT_HOST];
    assign m0_rvalid = rvalid_q[PORT_DMV];
    assign m1_rvalid = rvalid_q[PORT_HOST];
    assign m0_rdata  = din;
    assign m1_rdata  = din;
    assign daddr     = daddr_q;
    assign denb      = denb_q;
    assign dwenb     = dwenb_q;
    assign dout      = dout_q;

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Shares one single-port, 1-cycle-read-latency data BRAM between two requesters: port 0, the datamover data port, and port 1, a host/debug loader. Round-robin arbitration with a registered req/gnt handshake. BRAM-side port names match the datamover data interface (daddr/denb/dwenb/dout/din), so the arbiter drops in between datamover and BRAM unchanged.

Parameters:
AWIDTH, 8, BRAM word-address width
DWIDTH, 32, data word width

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  reset, asynchronous, active-low
m0_req  in  1  port 0 access request, held until m0_gnt
m0_addr  in  AWIDTH  port 0 word address
m0_wen  in  1  port 0: 1=write, 0=read
m0_wdata  in  DWIDTH  port 0 write data
m0_gnt  out  1  port 0 access issued this cycle (1-cycle pulse)
m0_rdata  out  DWIDTH  read data to port 0 (= din)
m0_rvalid  out  1  m0_rdata valid (1-cycle pulse)
m1_req, m1_addr, m1_wen, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as port 0, for port 1
daddr  out  AWIDTH  BRAM address
denb  out  1  BRAM enable
dwenb  out  1  BRAM write enable
dout  out  DWIDTH  BRAM write data
din  in  DWIDTH  BRAM read data, valid cycle after read issue

Behaviour:
- Reset (rstn low, async): gnt, rvalid, denb, dwenb = 0; daddr, dout = 0; rr pointer = port 0 preferred; pending read dropped, no rvalid after reset release.
- Cycle N: arbiter samples reqs. Eligible = req high and that port's gnt not high this cycle (prevents re-grant of a held request).
- Cycle N+1, registered: winner's gnt=1; denb=1; daddr/dwenb/dout = winner's addr/wen/wdata captured at N. None eligible -> denb=0, gnts=0.
- Requester holds req/addr/wen/wdata stable until it sees gnt. It may drop req or present a new access in the gnt cycle; a new access is eligible only from the cycle after gnt.
- Read: rvalid to the granted port at N+2, with mX_rdata=din. Writes never assert rvalid.
- Round-robin: both eligible -> pointer port wins; pointer then moves to the other port. One eligible -> it wins, and pointer moves to the other port.
- Throughput: 1 access/cycle when ports alternate; a lone requester gets 1 access per 2 cycles.
- FSM per cycle: IDLE (denb=0) / ACC0 / ACC1 (denb=1, matching gnt). ACC->ACC allowed back-to-back only for opposite ports, unless lock (below).
- Read then write same address, different ports: ordered by grant order; read returns pre-write value.
- At most one gnt and one rvalid high in any cycle. gnt and rvalid of the same port may coincide (new access + previous read return).

Optional Feature:
BRAM_ARB_LOCK_EN. When defined, adds inputs m0_lock and m1_lock (1 bit each, sampled with req). If the last-granted port has lock=1 and req=1, it keeps ownership:
- the other port is ineligible;
- the locked port is re-granted every other cycle (eligibility rule unchanged);
- lock released once lock=0 at a sample.
Undefined: lock ports absent, pure round-robin.

Decomposition:
- Package bram_arb_pkg: typedef port_idx_t (1 bit); enum arb_state_t {IDLE, ACC0, ACC1}; localparams PORT_DMV=0, PORT_HOST=1.
- Sub-module bram_arb_rr: 2-way round-robin picker. Inputs: eligible vector, pointer (and lock when enabled). Outputs: one-hot winner, next pointer.

Test Plan:
- Port 0 only, read addr 0x10 (bram=0xDEADBEEF) -> m0_gnt, denb=1, daddr=0x10 one cycle later; m0_rvalid with 0xDEADBEEF the next cycle; m1 signals stay 0.
- Both request at the same cycle after reset: p0 read 0x01, p1 write 0x02=0x12345678 -> p0 granted first, p1 next cycle; bram[0x02]=0x12345678; only m0_rvalid pulses.
- Both hold req continuously for 8 accesses -> grants strictly alternate 0,1,0,1; denb high every cycle.
- p0 alone, 4 back-to-back reads 0x00..0x03 -> gnt every other cycle; rvalid data in address order.
- rstn low in the cycle between a p1 read grant and its rvalid -> m1_rvalid never asserts; all outputs 0 during reset.
- With BRAM_ARB_LOCK_EN: p0 lock=1, 3 reads while p1 requests -> p1 starved until p0 lock=0, then granted next.
